servo_ramp_gen: RTL and testbench
=================================

Name: servo_ramp_gen

Overview:
Upstream command stage for the PWM servo driver. It accepts a target position word over a valid/ready handshake. It then slews its registered duty output toward that target by STEP counts every TICK_DIV clock cycles. duty drives the PWM duty input directly, so the servo never receives a step change larger than STEP.

Parameters:
N, 8, width of target and duty words (matches PWM input width)
TICK_DIV, 100000, clocks per ramp step (1 ms at 100 MHz); minimum 1
STEP, 1, duty increment/decrement per ramp tick; 1..2^N-1
MIN_POS, 0, lower clamp bound (used only with RAMP_CLAMP_EN)
MAX_POS, 255, upper clamp bound (used only with RAMP_CLAMP_EN); MIN_POS <= MAX_POS

Ports:
Clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
target  input  N  requested position
target_valid  input  1  target is valid this cycle
target_ready  output  1  block can accept a target this cycle
duty  output  N  current ramped position; connects to the PWM duty input
busy  output  1  ramp in progress
done  output  1  one-cycle pulse when duty reaches the latched target

Behaviour:
- All outputs are registered. Tick counter width is $clog2(TICK_DIV), minimum 1 bit.
- Reset (reset==0 at posedge) applies in any state, including mid-ramp:
  - state=IDLE, duty=0, latched target=0, tick=0
  - target_ready=1, busy=0, done=0
  - Reset mid-ramp drops duty to 0 at that edge.
- States: IDLE, RAMP, DONE.
- IDLE:
  - target_ready=1, busy=0.
  - Accept on a posedge with target_valid=1 and target_ready=1: latch target (after clamp if enabled) and clear tick.
  - If latched target != duty, go to RAMP. If latched target == duty, go to DONE.
- RAMP:
  - target_ready=0, busy=1. target_valid is ignored; the source must hold or re-present it later.
  - tick counts 0..TICK_DIV-1 and wraps to 0.
  - On the edge where tick==TICK_DIV-1, duty moves toward the target by min(STEP, |target-duty|).
  - The difference is computed in N+1 bits: no wrap-around, and duty never overshoots the target.
  - When duty becomes equal to the target on that edge, go to DONE.
  - First step occurs TICK_DIV cycles after the accept edge; each further step comes TICK_DIV cycles later.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, target_ready=0, duty held. Then go to IDLE.
  - done is asserted the cycle after duty reaches the target. Case target==duty: done is asserted the cycle after the accept edge.
- duty holds its value in IDLE indefinitely.
- If reset and target_valid coincide, reset wins and nothing is latched.

Optional Feature:
- Macro RAMP_CLAMP_EN.
- Defined: the target is saturated into [MIN_POS, MAX_POS] before it is latched. A target below MIN_POS latches MIN_POS; a target above MAX_POS latches MAX_POS. This protects the servo's mechanical end-stops. Reset value of duty stays 0.
- Not defined: the target is latched unmodified, and MIN_POS/MAX_POS have no effect.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with target_valid=1 -> duty=0, target_ready=1, busy=0, done=0; nothing latched.
2. Ramp up (TICK_DIV=4, STEP=2): from duty=0, one-cycle valid with target=5 -> duty=2 at +4 cycles, 4 at +8, 5 at +12; busy=1 from +1 to +12; done=1 at +13 only; target_ready=1 at +14.
3. Ramp down (TICK_DIV=4, STEP=2): from duty=5, target=0 -> duty 3, 1, 0 at +4, +8, +12; done pulse at +13; no underflow.
4. Same target: with duty=7, target=7 accepted -> duty unchanged, busy never asserted, done=1 on the cycle after accept for one cycle.
5. Busy ignore and reset mid-ramp: during RAMP toward 5, present target=200 with valid -> target_ready=0 and the ramp still ends at 5. In a second ramp, drive reset=0 when duty=2 -> duty=0 and state IDLE at that edge, target_ready=1 the next cycle.
6. Clamp (MIN_POS=10, MAX_POS=200, STEP=255, TICK_DIV=1): target=250 -> duty=200 with RAMP_CLAMP_EN, duty=250 without it; target=3 -> duty=10 with RAMP_CLAMP_EN, duty=3 without it.

Source files
------------

// File: rtl/servo_ramp_gen.sv
// servo_ramp_gen: accepts a target position over valid/ready and slews the
// registered duty output toward it by at most STEP counts every TICK_DIV
// clocks, so the PWM stage downstream never sees a larger jump.
// Optional feature macro: RAMP_CLAMP_EN (saturate target into
// [MIN_POS, MAX_POS] before latching it).
// busy/done/target_ready are registered from the current state, so they
// trail the state register by one clock; duty is registered directly.
module servo_ramp_gen #(
    parameter int N        = 8,
    parameter int TICK_DIV = 100000,
    parameter int STEP     = 1,
    parameter int MIN_POS  = 0,
    parameter int MAX_POS  = 255
) (
    input  logic         Clock,
    input  logic         reset,
    input  logic [N-1:0] target,
    input  logic         target_valid,
    output logic         target_ready,
    output logic [N-1:0] duty,
    output logic         busy,
    output logic         done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [N:0]    STEP_W    = (N+1)'(STEP);
    localparam logic [N-1:0]  MIN_V     = N'(MIN_POS);
    localparam logic [N-1:0]  MAX_V     = N'(MAX_POS);

`ifdef RAMP_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RAMP, S_DONE} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   tgt_reg, tgt_next;
    logic [N-1:0]   duty_reg, duty_next;
    logic [TW-1:0]  tick_reg, tick_next;
    logic           ready_reg, ready_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;

    logic           accept;
    logic [N-1:0]   target_lim;
    logic           dir_up;
    logic [N:0]     diff;
    logic [N-1:0]   step_amt;
    logic [N-1:0]   duty_stepped;

    // Saturate the incoming target when clamping is built in
    generate
        if (CLAMP_EN) begin : g_clamp
            always_comb begin
                target_lim = target;
                if (target < MIN_V)
                    target_lim = MIN_V;
                else if (target > MAX_V)
                    target_lim = MAX_V;
            end
        end else begin : g_noclamp
            always_comb target_lim = target;
        end
    endgenerate

    // Distance to the target in N+1 bits and the clipped step toward it
    always_comb begin
        dir_up = (tgt_reg > duty_reg);
        if (dir_up)
            diff = {1'b0, tgt_reg} - {1'b0, duty_reg};
        else
            diff = {1'b0, duty_reg} - {1'b0, tgt_reg};
        if (diff > STEP_W)
            step_amt = STEP_W[N-1:0];
        else
            step_amt = diff[N-1:0];
        if (dir_up)
            duty_stepped = duty_reg + step_amt;
        else
            duty_stepped = duty_reg - step_amt;
    end

    assign accept = target_valid && ready_reg && (state_reg == S_IDLE);

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_next = state_reg;
        tgt_next   = tgt_reg;
        duty_next  = duty_reg;
        tick_next  = tick_reg;
        busy_next  = (state_reg == S_RAMP);
        done_next  = (state_reg == S_DONE);
        ready_next = (state_reg == S_IDLE) && !accept;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    tgt_next  = target_lim;
                    tick_next = '0;
                    if (target_lim != duty_reg)
                        state_next = S_RAMP;
                    else
                        state_next = S_DONE;
                end
            end
            S_RAMP: begin
                if (tick_reg == TICK_LAST) begin
                    tick_next = '0;
                    duty_next = duty_stepped;
                    if (duty_stepped == tgt_reg)
                        state_next = S_DONE;
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            tgt_reg   <= '0;
            duty_reg  <= '0;
            tick_reg  <= '0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
            duty_reg  <= duty_next;
            tick_reg  <= tick_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign target_ready = ready_reg;
    assign duty         = duty_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_servo_ramp_gen.sv
// Testbench for servo_ramp_gen: directed vectors, scoreboard queues for
// duty changes and done pulses checked by a separate monitor, plus
// cycle-exact timing checks in the stimulus process.
module tb_servo_ramp_gen;

    logic       Clock;
    logic       reset;
    logic [7:0] target_a, target_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic [7:0] duty_a, duty_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] duty_q[$];
    logic [7:0] done_q[$];
    bit         mon_en = 1'b0;
    logic [7:0] prev_duty;

    servo_ramp_gen #(.N(8), .TICK_DIV(4), .STEP(2), .MIN_POS(0), .MAX_POS(255)) u_dut_a (
        .Clock(Clock), .reset(reset), .target(target_a), .target_valid(valid_a),
        .target_ready(ready_a), .duty(duty_a), .busy(busy_a), .done(done_a)
    );

    servo_ramp_gen #(.N(8), .TICK_DIV(1), .STEP(255), .MIN_POS(10), .MAX_POS(200)) u_dut_b (
        .Clock(Clock), .reset(reset), .target(target_b), .target_valid(valid_b),
        .target_ready(ready_b), .duty(duty_b), .busy(busy_b), .done(done_b)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every duty change and every done pulse is matched against the scoreboard
    always @(negedge Clock) begin
        if (!mon_en) begin
            prev_duty = duty_a;
        end else begin
            if (duty_a !== prev_duty) begin
                if (duty_q.size() == 0) begin
                    check("sb_duty_unexpected", duty_a, prev_duty);
                end else begin
                    check("sb_duty_change", duty_a, duty_q.pop_front());
                end
                prev_duty = duty_a;
            end
            if (done_a === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("sb_done_unexpected", 32'd1, 32'd0);
                end else begin
                    check("sb_done_duty", duty_a, done_q.pop_front());
                end
            end
        end
    end

    // Accept one target on DUT A and check every cycle until ready returns.
    // nsteps ramp ticks are expected; inject presents a competing target mid-ramp.
    task automatic do_ramp(input logic [7:0] tgt, input logic [7:0] start,
                           input int nsteps, input bit inject);
        logic [7:0] exp_duty;
        int         e;
        check("pre_ready", ready_a, 1'b1);
        $display("txn A: target=%0d from duty=%0d at %0t", tgt, start, $time);
        target_a = tgt;
        valid_a  = 1'b1;
        @(posedge Clock); #1;
        valid_a  = 1'b0;
        exp_duty = start;
        e = 4 * nsteps;
        for (int k = 1; k <= e + 2; k++) begin
            @(posedge Clock); #1;
            if ((k % 4 == 0) && (k <= e)) begin
                if (tgt > exp_duty)
                    exp_duty = (tgt - exp_duty > 2) ? exp_duty + 8'd2 : tgt;
                else
                    exp_duty = (exp_duty - tgt > 2) ? exp_duty - 8'd2 : tgt;
            end
            check("duty", duty_a, exp_duty);
            check("busy", busy_a, (k <= e) ? 1'b1 : 1'b0);
            check("done", done_a, (k == e + 1) ? 1'b1 : 1'b0);
            check("ready", ready_a, (k >= e + 2) ? 1'b1 : 1'b0);
            if (inject && k == 1) begin
                target_a = 8'd200;
                valid_a  = 1'b1;
            end
            if (inject && k == 3) begin
                valid_a = 1'b0;
            end
        end
    endtask

    // Accept one target on DUT B and wait (bounded) for its done pulse
    task automatic do_clamp(input logic [7:0] tgt, input logic [7:0] exp);
        bit seen;
        $display("txn B: target=%0d at %0t", tgt, $time);
        target_b = tgt;
        valid_b  = 1'b1;
        @(posedge Clock); #1;
        valid_b  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge Clock); #1;
            if (done_b === 1'b1) seen = 1'b1;
        end
        check("clamp_done_seen", seen, 1'b1);
        check("clamp_duty", duty_b, exp);
        @(posedge Clock); #1;
        check("clamp_ready", ready_b, 1'b1);
    endtask

    initial begin
        reset    = 1'b0;
        target_a = 8'd99;
        valid_a  = 1'b1;
        target_b = 8'd99;
        valid_b  = 1'b1;

        // Reset held with valid asserted
        repeat (3) @(posedge Clock);
        #1;
        check("rst_duty", duty_a, 8'd0);
        check("rst_ready", ready_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_duty_b", duty_b, 8'd0);
        reset   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        mon_en  = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check("post_rst_ready", ready_a, 1'b1);
        check("post_rst_busy", busy_a, 1'b0);
        check("post_rst_duty", duty_a, 8'd0);

        // Ramp up 0 -> 5
        duty_q.push_back(8'd2); duty_q.push_back(8'd4); duty_q.push_back(8'd5);
        done_q.push_back(8'd5);
        do_ramp(8'd5, 8'd0, 3, 1'b0);

        // Ramp down 5 -> 0
        duty_q.push_back(8'd3); duty_q.push_back(8'd1); duty_q.push_back(8'd0);
        done_q.push_back(8'd0);
        do_ramp(8'd0, 8'd5, 3, 1'b0);

        // Ramp up 0 -> 7, then same target 7
        duty_q.push_back(8'd2); duty_q.push_back(8'd4);
        duty_q.push_back(8'd6); duty_q.push_back(8'd7);
        done_q.push_back(8'd7);
        do_ramp(8'd7, 8'd0, 4, 1'b0);
        done_q.push_back(8'd7);
        do_ramp(8'd7, 8'd7, 0, 1'b0);

        // Ramp 7 -> 5 while a competing target of 200 is presented
        duty_q.push_back(8'd5);
        done_q.push_back(8'd5);
        do_ramp(8'd5, 8'd7, 1, 1'b1);

        // Back to 0, then reset in the middle of a ramp toward 6
        duty_q.push_back(8'd3); duty_q.push_back(8'd1); duty_q.push_back(8'd0);
        done_q.push_back(8'd0);
        do_ramp(8'd0, 8'd5, 3, 1'b0);
        duty_q.push_back(8'd2); duty_q.push_back(8'd0);
        $display("txn A: target=6 aborted by reset at %0t", $time);
        target_a = 8'd6;
        valid_a  = 1'b1;
        @(posedge Clock); #1;
        valid_a  = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        check("abort_duty_before", duty_a, 8'd2);
        check("abort_busy_before", busy_a, 1'b1);
        reset = 1'b0;
        @(posedge Clock); #1;
        reset = 1'b1;
        check("abort_duty", duty_a, 8'd0);
        check("abort_busy", busy_a, 1'b0);
        check("abort_ready", ready_a, 1'b1);
        @(posedge Clock); #1;
        check("abort_ready_next", ready_a, 1'b1);
        check("abort_duty_next", duty_a, 8'd0);

        // Clamp behaviour on DUT B
`ifdef RAMP_CLAMP_EN
        do_clamp(8'd250, 8'd200);
        do_clamp(8'd3, 8'd10);
`else
        do_clamp(8'd250, 8'd250);
        do_clamp(8'd3, 8'd3);
`endif

        repeat (2) @(posedge Clock);
        #1;
        check("sb_duty_left", duty_q.size(), 0);
        check("sb_done_left", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung simulation
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
